// File: rtl/jk_bank_ctrl.sv
// Two-requester, round-robin controller that drives a W-bit JK flip-flop bank.
// It sets, clears, toggles (with repeat) or holds the masked bits of the bank.
module jk_bank_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [1:0]   cmd0,
  input  logic [W-1:0] mask0,
  input  logic [3:0]   rep0,
  input  logic         req1,
  input  logic [1:0]   cmd1,
  input  logic [W-1:0] mask1,
  input  logic [3:0]   rep1,
  output logic         ack0,
  output logic         ack1,
  output logic         busy,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic [W-1:0] q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_ACK
  } state_t;

  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  state_t         state, next_state;
  logic           last_grant;
  logic           gnt;
  logic [1:0]     cmd_r;
  logic [W-1:0]   mask_r;
  logic [3:0]     cnt;

  logic           grant_any;
  logic           grant_sel;
  logic [1:0]     sel_cmd;
  logic [W-1:0]   sel_mask;
  logic [3:0]     sel_rep;
  logic [3:0]     load_cnt;

  // Arbitration and next-state logic.
  always_comb begin
    next_state = state;
    grant_any  = 1'b0;
    grant_sel  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_any  = 1'b1;
          grant_sel  = (req0 && req1) ? ~last_grant : req1;
          next_state = S_APPLY;
        end
      end
      S_APPLY: begin
        if (cnt <= 4'd1) next_state = S_ACK;
      end
      S_ACK:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    sel_cmd  = grant_sel ? cmd1  : cmd0;
    sel_mask = grant_sel ? mask1 : mask0;
    sel_rep  = grant_sel ? rep1  : rep0;
    load_cnt = 4'd1;
    if (sel_cmd == CMD_TOGGLE && sel_rep != 4'd0) load_cnt = sel_rep;
  end

  // last_grant resets to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      cmd_r      <= '0;
      mask_r     <= '0;
      cnt        <= '0;
    end else begin
      state <= next_state;
      if (grant_any) begin
        gnt        <= grant_sel;
        last_grant <= grant_sel;
        cmd_r      <= sel_cmd;
        mask_r     <= sel_mask;
        cnt        <= load_cnt;
      end else if (state == S_APPLY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Opcode bit 0 drives J and bit 1 drives K for every selected bit.
  always_comb begin
    j    = '0;
    k    = '0;
    ack0 = 1'b0;
    ack1 = 1'b0;
    busy = (state != S_IDLE);
    if (state == S_APPLY) begin
      j = mask_r & {W{cmd_r[0]}};
      k = mask_r & {W{cmd_r[1]}};
    end
    if (state == S_ACK) begin
      ack0 = ~gnt;
      ack1 = gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= (j & ~q) | (~k & q);
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed self-checking bench for jk_bank_ctrl (W = 8).
module tb_jk_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [1:0] cmd0, cmd1;
  logic [7:0] mask0, mask1;
  logic [3:0] rep0, rep1;
  logic       ack0, ack1, busy;
  logic [7:0] j, k, q;

  int checks = 0;
  int errors = 0;

  jk_bank_ctrl #(.W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .cmd0(cmd0), .mask0(mask0), .rep0(rep0),
    .req1(req1), .cmd1(cmd1), .mask1(mask1), .rep1(rep1),
    .ack0(ack0), .ack1(ack1), .busy(busy),
    .j(j), .k(k), .q(q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 0; req1 = 0;
    cmd0 = 0; cmd1 = 0; mask0 = 0; mask1 = 0; rep0 = 0; rep1 = 0;
    #2;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", {ack0, ack1}); end
    checks++; if ({j, k} !== 16'h0000) begin errors++; $display("FAIL reset_jk got %h want 0000", {j, k}); end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_set();
    req0 = 1; cmd0 = 2'b01; mask0 = 8'h0F; rep0 = 4'd9;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL set_busy_apply got %b want 1", busy); end
    checks++; if (j !== 8'h0F || k !== 8'h00) begin errors++; $display("FAIL set_jk got j=%h k=%h want j=0f k=00", j, k); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL set_q_before got %h want 00", q); end
    tick();
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL set_q got %h want 0f", q); end
    checks++; if ({ack0, ack1, busy} !== 3'b101) begin errors++; $display("FAIL set_ack got ack0/ack1/busy=%b want 101", {ack0, ack1, busy}); end
    req0 = 0;
    tick();
    checks++; if ({ack0, busy} !== 2'b00) begin errors++; $display("FAIL set_done got ack0/busy=%b want 00", {ack0, busy}); end
  endtask

  task automatic test_toggle_rep();
    req1 = 1; cmd1 = 2'b11; mask1 = 8'h01; rep1 = 4'd3;
    tick();
    checks++; if (j !== 8'h01 || k !== 8'h01 || q !== 8'h0F) begin errors++; $display("FAIL tog_apply1 got j=%h k=%h q=%h want 01 01 0f", j, k, q); end
    tick();
    checks++; if (q !== 8'h0E || ack1 !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tog_step1 got q=%h ack1=%b busy=%b want 0e 0 1", q, ack1, busy); end
    tick();
    checks++; if (q !== 8'h0F || ack1 !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tog_step2 got q=%h ack1=%b busy=%b want 0f 0 1", q, ack1, busy); end
    tick();
    checks++; if (q !== 8'h0E || {ack0, ack1} !== 2'b01) begin errors++; $display("FAIL tog_step3 got q=%h acks=%b want 0e 01", q, {ack0, ack1}); end
    req1 = 0;
    tick();
    checks++; if (busy !== 1'b0 || q !== 8'h0E) begin errors++; $display("FAIL tog_done got busy=%b q=%h want 0 0e", busy, q); end
  endtask

  task automatic test_round_robin();
    int n = 0;
    bit prev_ack = 0;
    rst = 1; req0 = 1; req1 = 1; cmd0 = 2'b10; cmd1 = 2'b10;
    mask0 = 8'hFF; mask1 = 8'hFF; rep0 = 0; rep1 = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      tick();
      if (prev_ack) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_gap op=%0d got busy=%b want 0", n, busy); end
        prev_ack = 0;
      end
      if (ack0 && ack1) begin
        checks++; errors++; $display("FAIL rr_overlap got ack0=1 ack1=1 want one-hot");
      end else if (ack0 || ack1) begin
        checks++;
        if (ack1 !== n[0]) begin errors++; $display("FAIL rr_order op=%0d got ack1=%b want %b", n, ack1, n[0]); end
        n++;
        prev_ack = 1;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL rr_timeout got %0d acks want 4", n); end
    req0 = 0; req1 = 0;
    tick();
    checks++; if (busy !== 1'b0 || q !== 8'h00) begin errors++; $display("FAIL rr_end got busy=%b q=%h want 0 00", busy, q); end
  endtask

  task automatic test_rep0();
    req0 = 1; cmd0 = 2'b11; mask0 = 8'hFF; rep0 = 4'd0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rep0_busy got %b want 1", busy); end
    tick();
    checks++; if (q !== 8'hFF || ack0 !== 1'b1) begin errors++; $display("FAIL rep0_once got q=%h ack0=%b want ff 1", q, ack0); end
    req0 = 0;
    tick();
    checks++; if (busy !== 1'b0 || q !== 8'hFF) begin errors++; $display("FAIL rep0_done got busy=%b q=%h want 0 ff", busy, q); end
  endtask

  task automatic test_reset_mid();
    req0 = 1; cmd0 = 2'b11; mask0 = 8'h01; rep0 = 4'd5;
    tick();
    tick();
    checks++; if (q !== 8'hFE || busy !== 1'b1) begin errors++; $display("FAIL mid_pre got q=%h busy=%b want fe 1", q, busy); end
    rst = 1;
    #1;
    checks++; if (q !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL mid_async got q=%h busy=%b want 00 0", q, busy); end
    checks++; if ({ack0, ack1} !== 2'b00 || {j, k} !== 16'h0) begin errors++; $display("FAIL mid_outs got acks=%b jk=%h want 00 0000", {ack0, ack1}, {j, k}); end
    req0 = 0;
    tick();
    checks++; if ({ack0, ack1, busy} !== 3'b000) begin errors++; $display("FAIL mid_noack got %b want 000", {ack0, ack1, busy}); end
    rst = 0;
    tick();
    checks++; if (q !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL mid_hold got q=%h busy=%b want 00 0", q, busy); end
    req0 = 1; req1 = 1; cmd0 = 2'b01; cmd1 = 2'b01; mask0 = 8'h3C; mask1 = 8'hC3;
    tick();
    tick();
    checks++; if ({ack0, ack1} !== 2'b10 || q !== 8'h3C) begin errors++; $display("FAIL mid_tie got acks=%b q=%h want 10 3c", {ack0, ack1}, q); end
    req0 = 0; req1 = 0;
    tick();
    checks++; if (busy !== 1'b0 || q !== 8'h3C) begin errors++; $display("FAIL mid_done got busy=%b q=%h want 0 3c", busy, q); end
  endtask

  task automatic test_midop_change();
    req0 = 1; cmd0 = 2'b00; mask0 = 8'hFF; rep0 = 0;
    tick();
    cmd0 = 2'b10; rep0 = 4'd7;
    #1;
    checks++; if ({j, k} !== 16'h0000) begin errors++; $display("FAIL chg_hold_jk got %h want 0000", {j, k}); end
    tick();
    checks++; if (q !== 8'h3C || ack0 !== 1'b1) begin errors++; $display("FAIL chg_hold got q=%h ack0=%b want 3c 1", q, ack0); end
    req0 = 0;
    tick();
    req0 = 1; cmd0 = 2'b01; mask0 = 8'hC0;
    tick();
    cmd0 = 2'b10; mask0 = 8'hFF;
    tick();
    checks++; if (q !== 8'hFC || ack0 !== 1'b1) begin errors++; $display("FAIL chg_set got q=%h ack0=%b want fc 1", q, ack0); end
    req0 = 0;
    tick();
    checks++; if (busy !== 1'b0 || q !== 8'hFC) begin errors++; $display("FAIL chg_done got busy=%b q=%h want 0 fc", busy, q); end
  endtask

  initial begin
    test_reset();
    test_set();
    test_toggle_rep();
    test_round_robin();
    test_rep0();
    test_reset_mid();
    test_midop_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
